// File: rtl/mem_map_pkg.sv
// Shared address map, TCON bit positions and device-select decode for the
// data-side memory bus controller.
package mem_map_pkg;

    localparam logic [31:0] MMIO_BASE    = 32'h4000_0000;
    localparam logic [31:0] TH_ADDR      = MMIO_BASE + 32'h00;
    localparam logic [31:0] TL_ADDR      = MMIO_BASE + 32'h04;
    localparam logic [31:0] TCON_ADDR    = MMIO_BASE + 32'h08;
    localparam logic [31:0] LED_ADDR     = MMIO_BASE + 32'h0C;
    localparam logic [31:0] DIGI_ADDR    = MMIO_BASE + 32'h10;
    localparam logic [31:0] SYSTICK_ADDR = MMIO_BASE + 32'h14;

    localparam int TCON_W      = 3;
    localparam int TCON_EN_BIT = 0;
    localparam int TCON_IE_BIT = 1;
    localparam int TCON_ST_BIT = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_DIGI,
        SEL_SYSTICK
    } dev_sel_e;

    // Word-address decode of the MMIO window; RAM is decoded by the caller
    // because its extent depends on a module parameter.
    function automatic dev_sel_e mmio_sel(input logic [29:0] word_addr);
        case (word_addr)
            TH_ADDR[31:2]:      return SEL_TH;
            TL_ADDR[31:2]:      return SEL_TL;
            TCON_ADDR[31:2]:    return SEL_TCON;
            LED_ADDR[31:2]:     return SEL_LED;
            DIGI_ADDR[31:2]:    return SEL_DIGI;
            SYSTICK_ADDR[31:2]: return SEL_SYSTICK;
            default:            return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// MEM-stage data bus between the pipeline (master) and the memory/peripheral
// controller (slave). Read data is combinational from the slave.
interface mem_bus_ctrl_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemBus_Address;
    logic [31:0] MemBus_Write_Data;
    logic [31:0] Device_Read_Data;

    modport master (
        output MemRead,
        output MemWrite,
        output MemBus_Address,
        output MemBus_Write_Data,
        input  Device_Read_Data
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  MemBus_Address,
        input  MemBus_Write_Data,
        output Device_Read_Data
    );
endinterface

// File: rtl/mmio_timer.sv
// Reloading up-counter timer: TH holds the reload value, TL counts up,
// TCON = {status, irq_enable, enable}. Level irq while status and enable set.
module mmio_timer
    import mem_map_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_th,
    input  logic               wr_tl,
    input  logic               wr_tcon,
    input  logic [TIMER_W-1:0] wdata_timer,
    input  logic [TCON_W-1:0]  wdata_tcon,
    output logic [31:0]        th_rd,
    output logic [31:0]        tl_rd,
    output logic [31:0]        tcon_rd,
    output logic               irq
);

    logic [TIMER_W-1:0] th_reg;
    logic [TIMER_W-1:0] tl_reg;
    logic [TCON_W-1:0]  tcon_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            th_reg   <= '0;
            tl_reg   <= '0;
            tcon_reg <= '0;
        end else begin
            if (wr_th)   th_reg   <= wdata_timer;
            if (wr_tl)   tl_reg   <= wdata_timer;
            if (wr_tcon) tcon_reg <= wdata_tcon;
            // A CPU write to TL or TCON owns this edge: no count, reload or status.
            if (!wr_tl && !wr_tcon && tcon_reg[TCON_EN_BIT]) begin
                if (tl_reg == '1) begin
                    tl_reg <= th_reg;
                    if (tcon_reg[TCON_IE_BIT]) tcon_reg[TCON_ST_BIT] <= 1'b1;
                end else begin
                    tl_reg <= tl_reg + 1'b1;
                end
            end
        end
    end

    always_comb begin
        th_rd   = '0;
        tl_rd   = '0;
        tcon_rd = '0;
        th_rd[TIMER_W-1:0]  = th_reg;
        tl_rd[TIMER_W-1:0]  = tl_reg;
        tcon_rd[TCON_W-1:0] = tcon_reg;
    end

    assign irq = tcon_reg[TCON_ST_BIT] & tcon_reg[TCON_IE_BIT];

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage data RAM + MMIO controller (LEDs, 7-seg, SYSTICK, optional timer).
// Define MEM_BUS_TIMER_EN to build the TH/TL/TCON timer and its irq.
module mem_bus_ctrl
    import mem_map_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int TIMER_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    mem_bus_ctrl_if.slave bus,
    output logic [7:0]  leds,
    output logic [11:0] digits,
    output logic        irq
);

    localparam int RAM_AW = $clog2(RAM_WORDS);

    logic [31:0]       ram_mem [RAM_WORDS];
    logic [7:0]        leds_reg;
    logic [11:0]       digits_reg;
    logic [31:0]       systick_reg;
    logic              ram_hit;
    logic [RAM_AW-1:0] ram_idx;
    dev_sel_e          sel;
    logic              unused_addr_bits;

    assign ram_hit = (bus.MemBus_Address[31:RAM_AW+2] == '0);
    assign ram_idx = bus.MemBus_Address[RAM_AW+1:2];
    assign sel     = ram_hit ? SEL_RAM : mmio_sel(bus.MemBus_Address[31:2]);

    // Byte-lane bits are ignored by the word-only bus.
    assign unused_addr_bits = ^bus.MemBus_Address[1:0];

    // RAM has no reset path so a write coinciding with reset still lands.
    always_ff @(posedge clk) begin
        if (bus.MemWrite && sel == SEL_RAM) ram_mem[ram_idx] <= bus.MemBus_Write_Data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds_reg    <= '0;
            digits_reg  <= '0;
            systick_reg <= '0;
        end else begin
            systick_reg <= systick_reg + 32'd1;
            if (bus.MemWrite && sel == SEL_LED)  leds_reg   <= bus.MemBus_Write_Data[7:0];
            if (bus.MemWrite && sel == SEL_DIGI) digits_reg <= bus.MemBus_Write_Data[11:0];
        end
    end

    assign leds   = leds_reg;
    assign digits = digits_reg;

`ifdef MEM_BUS_TIMER_EN
    logic [31:0] th_rd;
    logic [31:0] tl_rd;
    logic [31:0] tcon_rd;

    mmio_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .wr_th       (bus.MemWrite && sel == SEL_TH),
        .wr_tl       (bus.MemWrite && sel == SEL_TL),
        .wr_tcon     (bus.MemWrite && sel == SEL_TCON),
        .wdata_timer (bus.MemBus_Write_Data[TIMER_W-1:0]),
        .wdata_tcon  (bus.MemBus_Write_Data[TCON_W-1:0]),
        .th_rd       (th_rd),
        .tl_rd       (tl_rd),
        .tcon_rd     (tcon_rd),
        .irq         (irq)
    );
`else
    localparam int unused_timer_w = TIMER_W;
    assign irq = 1'b0;
`endif

    always_comb begin
        bus.Device_Read_Data = '0;
        if (bus.MemRead) begin
            case (sel)
                SEL_RAM:     bus.Device_Read_Data = ram_mem[ram_idx];
                SEL_LED:     bus.Device_Read_Data = {24'd0, leds_reg};
                SEL_DIGI:    bus.Device_Read_Data = {20'd0, digits_reg};
                SEL_SYSTICK: bus.Device_Read_Data = systick_reg;
`ifdef MEM_BUS_TIMER_EN
                SEL_TH:      bus.Device_Read_Data = th_rd;
                SEL_TL:      bus.Device_Read_Data = tl_rd;
                SEL_TCON:    bus.Device_Read_Data = tcon_rd;
`endif
                default:     bus.Device_Read_Data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: vector table for RAM/MMIO decode plus
// hand-written timer, SYSTICK and reset sequences.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

    localparam logic [31:0] TH_A   = 32'h4000_0000;
    localparam logic [31:0] TL_A   = 32'h4000_0004;
    localparam logic [31:0] TCON_A = 32'h4000_0008;
    localparam logic [31:0] LED_A  = 32'h4000_000C;
    localparam logic [31:0] DIGI_A = 32'h4000_0010;
    localparam logic [31:0] TICK_A = 32'h4000_0014;
`ifdef MEM_BUS_TIMER_EN
    localparam logic [31:0] TCON_RB = 32'd3;
`else
    localparam logic [31:0] TCON_RB = 32'd0;
`endif

    typedef struct packed {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NVEC = 19;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  leds;
    logic [11:0] digits;
    logic        irq;
    int          tests = 0;
    int          fails = 0;
    vec_t        vecs [NVEC];

    mem_bus_ctrl_if bus ();

    mem_bus_ctrl #(
        .RAM_WORDS (256),
        .TIMER_W   (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .leds   (leds),
        .digits (digits),
        .irq    (irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    task automatic idle(input int n);
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.MemRead           = 1'b0;
        bus.MemWrite          = 1'b1;
        bus.MemBus_Address    = a;
        bus.MemBus_Write_Data = d;
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
    endtask

    // Combinational read within the current cycle; consumes no clock edge.
    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.MemRead        = 1'b1;
        bus.MemBus_Address = a;
        #1;
        check(name, bus.Device_Read_Data, exp);
        bus.MemRead = 1'b0;
    endtask

    initial begin
        logic [31:0] tick0;
        logic        irq_seen;

        //           we    re    addr          wdata         exp_rd
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_0400, 32'hAAAA_AAAA, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'h1111_1111};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h0,         32'h0};
        vecs[7]  = '{1'b1, 1'b1, LED_A,         32'h0000_01A5, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, LED_A,         32'h0,         32'h0000_00A5};
        vecs[9]  = '{1'b1, 1'b1, DIGI_A,        32'hFFFF_F123, 32'h0};
        vecs[10] = '{1'b0, 1'b1, DIGI_A,        32'h0,         32'h0000_0123};
        vecs[11] = '{1'b1, 1'b1, DIGI_A,        32'h0000_0456, 32'h0000_0123};
        vecs[12] = '{1'b0, 1'b1, DIGI_A,        32'h0,         32'h0000_0456};
        vecs[13] = '{1'b0, 1'b1, 32'h4000_0020, 32'h0,         32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h4000_0020, 32'h0000_0055, 32'h0};
        vecs[15] = '{1'b0, 1'b1, 32'h4000_0020, 32'h0,         32'h0};
        vecs[16] = '{1'b0, 1'b1, 32'h4000_000E, 32'h0,         32'h0000_00A5};
        vecs[17] = '{1'b1, 1'b0, TCON_A,        32'h0000_0003, 32'h0};
        vecs[18] = '{1'b0, 1'b1, TCON_A,        32'h0,         TCON_RB};

        bus.MemRead           = 1'b0;
        bus.MemWrite          = 1'b0;
        bus.MemBus_Address    = '0;
        bus.MemBus_Write_Data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_leds", {24'd0, leds}, 32'd0);
        check("rst_digits", {20'd0, digits}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd_chk("rst_systick", TICK_A, 32'd0);
        rd_chk("rst_tl", TL_A, 32'd0);
        rd_chk("rst_tcon", TCON_A, 32'd0);
        idle(1);

        // Vector table: read data is checked before the edge that commits the write
        for (int i = 0; i < NVEC; i++) begin
            bus.MemRead           = vecs[i].re;
            bus.MemWrite          = vecs[i].we;
            bus.MemBus_Address    = vecs[i].addr;
            bus.MemBus_Write_Data = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d", i), bus.Device_Read_Data, vecs[i].exp_rd);
            @(posedge clk);
            #1;
            bus.MemRead  = 1'b0;
            bus.MemWrite = 1'b0;
        end
        check("leds_port", {24'd0, leds}, 32'h0000_00A5);
        check("digits_port", {20'd0, digits}, 32'h0000_0456);

        // SYSTICK ignores writes and advances once per edge
        bus.MemRead        = 1'b1;
        bus.MemBus_Address = TICK_A;
        #1;
        tick0 = bus.Device_Read_Data;
        bus.MemRead = 1'b0;
        wr(TICK_A, 32'h0001_2345);
        idle(4);
        rd_chk("systick_advance", TICK_A, tick0 + 32'd5);

`ifdef MEM_BUS_TIMER_EN
        // Reload and status
        wr(TCON_A, 32'd0);
        wr(TH_A, 32'hFFFF_FFF0);
        wr(TL_A, 32'hFFFF_FFFE);
        wr(TCON_A, 32'd3);
        check("tmr_irq_pre", {31'd0, irq}, 32'd0);
        idle(1);
        rd_chk("tmr_tl_max", TL_A, 32'hFFFF_FFFF);
        check("tmr_irq_max", {31'd0, irq}, 32'd0);
        idle(1);
        rd_chk("tmr_tl_reload", TL_A, 32'hFFFF_FFF0);
        rd_chk("tmr_tcon_st", TCON_A, 32'd7);
        check("tmr_irq_set", {31'd0, irq}, 32'd1);
        wr(TCON_A, 32'd3);
        check("tmr_irq_clr", {31'd0, irq}, 32'd0);
        rd_chk("tmr_tcon_clr", TCON_A, 32'd3);

        // CPU write to TL collides with overflow
        wr(TCON_A, 32'd0);
        wr(TH_A, 32'h0000_0100);
        wr(TL_A, 32'hFFFF_FFFF);
        wr(TCON_A, 32'd3);
        wr(TL_A, 32'd5);
        rd_chk("coll_tl", TL_A, 32'd5);
        rd_chk("coll_tcon", TCON_A, 32'd3);
        check("coll_irq", {31'd0, irq}, 32'd0);
`else
        // Timer absent: registers read 0, irq never rises
        wr(TCON_A, 32'd3);
        rd_chk("notmr_tcon", TCON_A, 32'd0);
        wr(TL_A, 32'h1234_5678);
        rd_chk("notmr_tl", TL_A, 32'd0);
        wr(TL_A, 32'hFFFF_FFFF);
        wr(TCON_A, 32'd3);
        irq_seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (irq !== 1'b0) irq_seen = 1'b1;
        end
        check("notmr_irq_quiet", {31'd0, irq_seen}, 32'd0);
        @(posedge clk);
        #1;
`endif

        // Reset beats a register write but not a RAM write
        reset                 = 1'b1;
        bus.MemWrite          = 1'b1;
        bus.MemBus_Address    = LED_A;
        bus.MemBus_Write_Data = 32'h0000_003C;
        @(posedge clk);
        #1;
        bus.MemBus_Address    = 32'h0000_0018;
        bus.MemBus_Write_Data = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.MemWrite = 1'b0;
        check("rst2_leds", {24'd0, leds}, 32'd0);
        check("rst2_digits", {20'd0, digits}, 32'd0);
        check("rst2_irq", {31'd0, irq}, 32'd0);
        rd_chk("rst2_systick", TICK_A, 32'd0);
        rd_chk("rst2_tl", TL_A, 32'd0);
        rd_chk("rst2_tcon", TCON_A, 32'd0);
        rd_chk("rst2_ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("rst2_ram_wr", 32'h0000_0018, 32'hCAFE_F00D);
        idle(2);
        rd_chk("rst2_systick_run", TICK_A, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
